// File: rtl/vr_fifo_if.sv
// Valid/ready stream bundle for vr_fifo: upstream push side, downstream pop side,
// plus fill level and the sticky overflow flag.
interface vr_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CntW-1:0]  count;
  logic             drop;

  // Producer/consumer side that talks to the FIFO.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, drop
  );

  // The FIFO itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, drop
  );
endinterface

// File: rtl/vr_fifo.sv
// vr_fifo: first-word-fall-through synchronous FIFO turning the capture-register output
// into a valid/ready stream. Handshake flags depend only on the registered fill count.
// Optional macro VR_FIFO_DROP_EN: in_ready is held at 1 and words arriving while full are
// discarded, setting the sticky drop flag until reset.
module vr_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic      clk,
  input logic      reset,
  vr_fifo_if.slave bus_io
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty, push, pop;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // A full FIFO never accepts a word, even when a pop frees a slot in the same cycle.
  assign push = bus_io.in_valid && !full;
  assign pop  = bus_io.out_valid && bus_io.out_ready;

  assign bus_io.out_valid = !empty;
  assign bus_io.out_data  = mem_q[rd_ptr_q];
  assign bus_io.count     = count_q;

`ifdef VR_FIFO_DROP_EN
  logic drop_q, drop_d;

  assign bus_io.in_ready = 1'b1;
  assign bus_io.drop     = drop_q;

  // Sticky overflow flag: set by any word presented while full.
  always_comb begin
    drop_d = drop_q;
    if (bus_io.in_valid && full) begin
      drop_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end
`else
  assign bus_io.in_ready = !full;
  assign bus_io.drop     = 1'b0;
`endif

  // Next-state for pointers, fill count and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus_io.in_data;
      wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_vr_fifo.sv
// Directed testbench for vr_fifo (WIDTH=8, DEPTH=4). Builds with or without
// VR_FIFO_DROP_EN; expectations follow the selected mode.
module tb_vr_fifo;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  vr_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  vr_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VR_FIFO_DROP_EN
  localparam logic DropMode = 1'b1;
`else
  localparam logic DropMode = 1'b0;
`endif

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", bus.drop); end
  endtask

  task automatic test_first_word();
    do_reset();
    cyc(1'b1, 8'h11, 1'b0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_out_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 8'h11) begin bad++; $display("FAIL first_out_data got=%h want=11", bus.out_data); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d want=1", bus.count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL first_in_ready got=%b want=1", bus.in_ready); end
    cyc(1'b0, 8'h00, 1'b1);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL first_pop_count got=%0d want=0", bus.count); end
  endtask

  task automatic test_stable();
    do_reset();
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_data !== 8'h3C) begin bad++; $display("FAIL stable_hold[%0d] got=%h want=3c", i, bus.out_data); end
      cyc(1'b0, 8'hFF, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    total++; if (bus.out_data !== 8'h5A) begin bad++; $display("FAIL stable_next got=%h want=5a", bus.out_data); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", bus.count); end
    total++; if (bus.in_ready !== DropMode) begin bad++; $display("FAIL full_in_ready got=%b want=%b", bus.in_ready, DropMode); end
    cyc(1'b1, 8'h05, 1'b0);
    cyc(1'b1, 8'h05, 1'b0);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_hold_count got=%0d want=4", bus.count); end
    total++; if (bus.drop !== DropMode) begin bad++; $display("FAIL full_drop got=%b want=%b", bus.drop, DropMode); end
    for (int i = 1; i <= 4; i++) begin
      total++; if (bus.out_data !== 8'(i)) begin bad++; $display("FAIL full_pop[%0d] got=%h want=%h", i, bus.out_data, 8'(i)); end
      cyc(1'b0, 8'h00, 1'b1);
    end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL full_drain_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL full_drain_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.drop !== DropMode) begin bad++; $display("FAIL full_drop_sticky got=%b want=%b", bus.drop, DropMode); end
    do_reset();
    total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL full_drop_cleared got=%b want=0", bus.drop); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'h05, 1'b1);
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL fullpop_count got=%0d want=3", bus.count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_in_ready got=%b want=1", bus.in_ready); end
    cyc(1'b1, 8'h05, 1'b0);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fullpop_refill got=%0d want=4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_data !== exp_q[i]) begin bad++; $display("FAIL fullpop_order[%0d] got=%h want=%h", i, bus.out_data, exp_q[i]); end
      cyc(1'b0, 8'h00, 1'b1);
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] head;
    do_reset();
    cyc(1'b1, 8'h40, 1'b0);
    cyc(1'b1, 8'h41, 1'b0);
    head = 8'h40;
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.out_data !== head) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, bus.out_data, head); end
      cyc(1'b1, head + 8'd2, 1'b1);
      head = head + 8'd1;
      total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=2", i, bus.count); end
    end
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.out_data !== head) begin bad++; $display("FAIL b2b_tail[%0d] got=%h want=%h", i, bus.out_data, head); end
      cyc(1'b0, 8'h00, 1'b1);
      head = head + 8'd1;
    end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL b2b_final_count got=%0d want=0", bus.count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    reset = 1'b1;
    cyc(1'b1, 8'h77, 1'b1);
    reset = 1'b0;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL rstmid_drop got=%b want=0", bus.drop); end
    cyc(1'b1, 8'h99, 1'b0);
    total++; if (bus.out_data !== 8'h99) begin bad++; $display("FAIL rstmid_after got=%h want=99", bus.out_data); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_first_word();
    test_stable();
    test_full();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vr_fifo.md
Name: vr_fifo

Overview:
- Small synchronous FIFO that converts the level-valid capture-register output into a valid/ready stream for downstream consumers.
- Sits directly downstream of the clock-enable capture flop.
- Buffers up to DEPTH words.
- Supplies backpressure upstream or, optionally, drops words on overflow and records the event.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  FIFO holds at least one word.
- out_ready  input  1  downstream accepts the head word this cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- count  output  $clog2(DEPTH+1)  number of words held.
- drop  output  1  sticky: a word was discarded because the FIFO was full.

Behaviour:
- Reset is sampled at the rising edge of clk. Results:
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1, drop=0.
  - Storage array is not reset. out_data is don't-care while out_valid=0.
- Push occurs when in_valid && in_ready at the clock edge. Pop occurs when out_valid && out_ready at the clock edge.
- in_ready = (count != DEPTH). out_valid = (count != 0). Both are combinational from registered count only, with no combinational path from in_valid or out_ready.
- out_data = mem[rd_ptr], a combinational read of the registered array (first-word-fall-through).
- Latency: a word pushed at edge N gives out_valid=1 and out_data=that word after edge N. There is no same-cycle bypass.
- Pointers advance by 1 on push and pop respectively and wrap from DEPTH-1 to 0.
- count next-state:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Full (count==DEPTH): in_ready=0, so no push. A pop in the same cycle frees a slot, and in_ready=1 the following cycle. No write-through when full.
- Empty (count==0): out_valid=0, so no pop. A simultaneous in_valid pushes normally.
- Simultaneous push and pop at partial fill: both pointers advance, count holds, and ordering is preserved.
- Order is strictly first-in first-out. Data is never duplicated or reordered.
- out_data must remain stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all contents. out_valid drops to 0 after the reset edge, regardless of in_valid/out_ready during that cycle.
- count never exceeds DEPTH and never underflows. Verification asserts both properties.

Optional Feature:
- Macro VR_FIFO_DROP_EN.
- Defined:
  - in_ready is held constantly 1.
  - A word presented with in_valid=1 while count==DEPTH is discarded, even if a pop occurs in the same cycle. Storage, pointers and count are unchanged by the discarded word.
  - drop is set to 1 at that edge and stays 1 until reset.
  - This mode suits upstream stages that have no ready input.
- Not defined:
  - in_ready = (count != DEPTH) as specified above.
  - drop is tied to 0.
  - Overflow cannot occur.

Test Plan:
- Reset, then push 0x11 at edge 1 with out_ready=0 -> after edge 1: out_valid=1, out_data=0x11, count=1, in_ready=1.
- Push 0x01,0x02,0x03,0x04 with out_ready=0 -> count=4, in_ready=0. With in_valid held and in_data=0x05 for 2 cycles, contents are unchanged. Then pop 4 times -> outputs 0x01..0x04 in order, count=0, out_valid=0.
- Fill to 4, then one cycle with in_valid=1 (0x05) and out_ready=1 -> 0x01 popped, 0x05 not accepted, count=3. Next cycle in_ready=1 and push 0x05 -> final pop order 0x02,0x03,0x04,0x05.
- Count=2, then continuous push and pop for 10 cycles with incrementing data -> count stays 2. Pointers wrap at least twice. Output sequence equals input sequence delayed by 2 words.
- Fill to 3, assert reset for one edge while in_valid=1 and out_ready=1 -> after that edge count=0, out_valid=0, in_ready=1, drop=0.
- With VR_FIFO_DROP_EN: fill to 4, push 0xAA -> in_ready stays 1, drop=1, count=4. Pops yield the original 4 words; 0xAA never appears. drop stays 1 until reset.
